crc5_stream_ctrl: RTL

//  Frame sequencer for the nibble-parallel CRC5 datapath (poly x^5+x^2+1).
//  - Accepts a stream of 4-bit nibbles framed by valid/ready/last.
//  - Holds the running CRC state and feeds it back through the 4-bit step once per accepted nibble.
//  - Presents the finished CRC, nibble count and expected-value match on a held output handshake.
//  - Sits between the packet nibble source and the token/packet checker.

---
 rtl/crc5_stream_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/crc5_stream_ctrl.sv
// Frame sequencer around the nibble-parallel CRC5 step (x^5+x^2+1): accepts a
// valid/ready/last nibble stream and holds the finished CRC, length and match flag.
module crc5_stream_ctrl #(
  parameter logic [4:0]  INIT      = 5'h1F,
  parameter logic [4:0]  FINAL_XOR = 5'h1F,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       s_data,
  input  logic             s_last,
  input  logic [4:0]       exp_crc,
  output logic             crc_valid,
  input  logic             crc_ready,
  output logic [4:0]       crc_out,
  output logic             crc_match,
  output logic [CNT_W-1:0] crc_cnt,
  output logic             crc_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // One nibble through the CRC5 LFSR, data bit 3 entering first.
  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic [3:0] d);
    logic [4:0] n;
    n[0] = c[1] ^ c[4] ^ d[0] ^ d[3];
    n[1] = c[2] ^ d[1];
    n[2] = c[1] ^ c[3] ^ c[4] ^ d[0] ^ d[2] ^ d[3];
    n[3] = c[2] ^ c[4] ^ d[1] ^ d[3];
    n[4] = c[0] ^ c[3] ^ d[2];
    return n;
  endfunction

  state_e             state_q, state_d;
  logic [4:0]         lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               match_q, match_d;
  logic               ready_en_q;
  logic               accept_s;
  logic [4:0]         step_s;
  logic               hit_s;

  // ready_en_q keeps s_ready low until the first edge after reset release.
  assign s_ready   = ready_en_q & (state_q != ST_HOLD) & ~abort;
  assign accept_s  = s_valid & s_ready;
  assign crc_valid = (state_q == ST_HOLD);
  assign crc_out   = lfsr_q ^ FINAL_XOR;
  assign crc_match = match_q;
  assign crc_cnt   = cnt_q;
  assign crc_ovf   = ovf_q;

  always_comb begin
    step_s = crc5_step((state_q == ST_IDLE) ? INIT : lfsr_q, s_data);
    hit_s  = ((step_s ^ FINAL_XOR) == exp_crc);
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    match_d = match_q;
    if (abort) begin
      state_d = ST_IDLE;
      lfsr_d  = INIT;
      cnt_d   = CNT_ZERO;
      ovf_d   = 1'b0;
      match_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            lfsr_d  = step_s;
            cnt_d   = CNT_ONE;
            ovf_d   = 1'b0;
            state_d = s_last ? ST_HOLD : ST_ACC;
            match_d = s_last & hit_s;
          end
        end
        ST_ACC: begin
          if (accept_s) begin
            lfsr_d = step_s;
            // The counter saturates; the CRC keeps running past the limit.
            if (cnt_q == CNT_MAX) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
            state_d = s_last ? ST_HOLD : ST_ACC;
            match_d = s_last & hit_s;
          end
        end
        ST_HOLD: begin
          if (crc_ready) begin
            state_d = ST_IDLE;
            lfsr_d  = INIT;
            cnt_d   = CNT_ZERO;
            ovf_d   = 1'b0;
            match_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          lfsr_d  = INIT;
          cnt_d   = CNT_ZERO;
          ovf_d   = 1'b0;
          match_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= INIT;
      cnt_q      <= CNT_ZERO;
      ovf_q      <= 1'b0;
      match_q    <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      match_q    <= match_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule
